// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA sequencer: FSM encoding, status/CTRL bit
// positions and the default result address in the register bank.
package rsa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_WB   = 2'd3
  } rsa_state_t;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_ERR_TO    = 2;
  localparam int STAT_ERR_ABORT = 3;

  localparam int CTRL_ADDR  = 0;
  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;

  localparam int DEFAULT_RESULT_ADDR = 5;

  // Counter width able to hold TIMEOUT_CYCLES-1, never narrower than one bit.
  function automatic int timer_width(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rsa_ctrl_timer.sv
// Clear/increment cycle counter; expire is high while the count sits at
// TIMEOUT_CYCLES-1, so an increment-only run expires after TIMEOUT_CYCLES cycles.
module rsa_ctrl_timer
  import rsa_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int TW = timer_width(TIMEOUT_CYCLES);

  logic [TW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && !expire) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (count == TW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/rsa_ctrl.sv
// Sequencer between the SPI register bank and the rsa_unit datapath: latches
// operands, runs the unit until eoc/timeout/abort and writes the result back.
module rsa_ctrl
  import rsa_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int ADDR_W         = 3,
  parameter int RESULT_ADDR    = DEFAULT_RESULT_ADDR,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_start,
  input  logic              cmd_abort,
  input  logic [WIDTH-1:0]  op_p,
  input  logic [WIDTH-1:0]  op_e,
  input  logic [WIDTH-1:0]  op_m,
  input  logic [WIDTH-1:0]  op_const,
  input  logic              spi_wr_vld,
  output logic              wb_vld,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [WIDTH-1:0]  wb_data,
  output logic              rsa_rst_n,
  output logic              rsa_en,
  output logic [WIDTH-1:0]  rsa_p,
  output logic [WIDTH-1:0]  rsa_e,
  output logic [WIDTH-1:0]  rsa_m,
  output logic [WIDTH-1:0]  rsa_const,
  input  logic              rsa_eoc,
  input  logic [WIDTH-1:0]  rsa_c,
  output logic [7:0]        status
);

  rsa_state_t state, state_nxt;

  logic [WIDTH-1:0] result;
  logic             done, err_timeout, err_abort;
  logic             busy;
  logic             timer_clr, timer_inc, timer_expire;
  logic             start_ok;

  rsa_ctrl_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr),
    .inc    (timer_inc),
    .expire (timer_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Abort outranks eoc, timeout and the writeback in every busy state.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    rsa_rst_n = 1'b0;
    rsa_en    = 1'b0;
    wb_vld    = 1'b0;
    timer_clr = 1'b0;
    timer_inc = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start_ok) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        timer_clr = 1'b1;
        state_nxt = cmd_abort ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        rsa_rst_n = 1'b1;
        rsa_en    = 1'b1;
        timer_inc = 1'b1;
        if (cmd_abort)         state_nxt = ST_IDLE;
        else if (rsa_eoc)      state_nxt = ST_WB;
        else if (timer_expire) state_nxt = ST_IDLE;
      end
      ST_WB: begin
        rsa_rst_n = 1'b1;
        wb_vld    = !spi_wr_vld && !cmd_abort;
        if (cmd_abort || !spi_wr_vld) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign start_ok = cmd_start && !cmd_abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsa_p       <= '0;
      rsa_e       <= '0;
      rsa_m       <= '0;
      rsa_const   <= '0;
      result      <= '0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      err_abort   <= 1'b0;
    end else begin
      if (state == ST_IDLE && start_ok) begin
        rsa_p       <= op_p;
        rsa_e       <= op_e;
        rsa_m       <= op_m;
        rsa_const   <= op_const;
        done        <= 1'b0;
        err_timeout <= 1'b0;
        err_abort   <= 1'b0;
      end
      if (state == ST_RUN && !cmd_abort) begin
        if (rsa_eoc) result <= rsa_c;
        else if (timer_expire) err_timeout <= 1'b1;
      end
      if (state != ST_IDLE && cmd_abort) err_abort <= 1'b1;
      if (wb_vld) done <= 1'b1;
    end
  end

  assign wb_addr = ADDR_W'(RESULT_ADDR);
  assign wb_data = result;

  always_comb begin
    status                 = '0;
    status[STAT_BUSY]      = busy;
    status[STAT_DONE]      = done;
    status[STAT_ERR_TO]    = err_timeout;
    status[STAT_ERR_ABORT] = err_abort;
  end

endmodule

// File: tb/tb_rsa_ctrl.sv
// Directed self-checking bench for rsa_ctrl; a scripted rsa_unit stand-in
// raises eoc at chosen RUN cycles and expected values are hand-computed.
module tb_rsa_ctrl;

  logic       clk, rst, cmd_start, cmd_abort, spi_wr_vld;
  logic [7:0] op_p, op_e, op_m, op_const;
  logic       wb_vld, rsa_rst_n, rsa_en, rsa_eoc;
  logic [2:0] wb_addr;
  logic [7:0] wb_data, rsa_p, rsa_e, rsa_m, rsa_const, rsa_c, status;

  int errors = 0;
  int checks = 0;
  int wb_count = 0;
  int overlap_count = 0;
  int wb_before;

  rsa_ctrl #(
    .WIDTH(8), .ADDR_W(3), .RESULT_ADDR(5), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .op_p(op_p), .op_e(op_e), .op_m(op_m), .op_const(op_const),
    .spi_wr_vld(spi_wr_vld), .wb_vld(wb_vld), .wb_addr(wb_addr),
    .wb_data(wb_data), .rsa_rst_n(rsa_rst_n), .rsa_en(rsa_en),
    .rsa_p(rsa_p), .rsa_e(rsa_e), .rsa_m(rsa_m), .rsa_const(rsa_const),
    .rsa_eoc(rsa_eoc), .rsa_c(rsa_c), .status(status)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Write-port activity observed mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (wb_vld) wb_count++;
    if (wb_vld && spi_wr_vld) overlap_count++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Pulse start with the given operands; returns in the LOAD cycle.
  task automatic start_op(input logic [7:0] p, e, m, c);
    op_p = p; op_e = e; op_m = m; op_const = c;
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    #1;
    checks++;
    if (status !== 8'h00) begin errors++; $display("[TB] FAIL reset_status got=%h exp=00", status); end
    checks++;
    if ({wb_vld, rsa_en, rsa_rst_n} !== 3'b000) begin errors++; $display("[TB] FAIL reset_ctl got=%b exp=000", {wb_vld, rsa_en, rsa_rst_n}); end
    checks++;
    if ({rsa_p, rsa_e, rsa_m, rsa_const, wb_data} !== 40'h0) begin errors++; $display("[TB] FAIL reset_regs got=%h exp=0", {rsa_p, rsa_e, rsa_m, rsa_const, wb_data}); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    wb_before = wb_count;
    start_op(8'd33, 8'd3, 8'd4, 8'd7);
    #1;
    checks++;
    if ({status, rsa_rst_n, rsa_en} !== {8'h01, 2'b00}) begin errors++; $display("[TB] FAIL basic_load got=%h/%b%b exp=01/00", status, rsa_rst_n, rsa_en); end
    checks++;
    if ({rsa_p, rsa_e, rsa_m, rsa_const} !== {8'd33, 8'd3, 8'd4, 8'd7}) begin errors++; $display("[TB] FAIL basic_latch got=%h exp=21030407", {rsa_p, rsa_e, rsa_m, rsa_const}); end
    step();
    #1;
    checks++;
    if ({rsa_rst_n, rsa_en} !== 2'b11) begin errors++; $display("[TB] FAIL basic_run got=%b exp=11", {rsa_rst_n, rsa_en}); end
    for (int i = 1; i <= 10; i++) begin
      if (i == 10) begin rsa_eoc = 1'b1; rsa_c = 8'd31; end
      step();
    end
    rsa_eoc = 1'b0; rsa_c = 8'd0;
    #1;
    checks++;
    if ({wb_vld, wb_addr, wb_data, rsa_en} !== {1'b1, 3'd5, 8'd31, 1'b0}) begin errors++; $display("[TB] FAIL basic_wb got=%b/%0d/%0d/%b exp=1/5/31/0", wb_vld, wb_addr, wb_data, rsa_en); end
    step();
    #1;
    checks++;
    if ({status, wb_vld} !== {8'h02, 1'b0}) begin errors++; $display("[TB] FAIL basic_done got=%h/%b exp=02/0", status, wb_vld); end
    checks++;
    if (wb_count - wb_before !== 1) begin errors++; $display("[TB] FAIL basic_wb_count got=%0d exp=1", wb_count - wb_before); end
  endtask

  task automatic test_contention();
    wb_before = wb_count;
    start_op(8'd33, 8'd3, 8'd4, 8'd7);
    step();
    repeat (9) step();
    rsa_eoc = 1'b1; rsa_c = 8'd31;
    step();
    rsa_eoc = 1'b0; rsa_c = 8'd0;
    spi_wr_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({wb_vld, status} !== {1'b0, 8'h01}) begin errors++; $display("[TB] FAIL cont_hold%0d got=%b/%h exp=0/01", i, wb_vld, status); end
      step();
    end
    spi_wr_vld = 1'b0;
    #1;
    checks++;
    if ({wb_vld, wb_data} !== {1'b1, 8'd31}) begin errors++; $display("[TB] FAIL cont_wb got=%b/%0d exp=1/31", wb_vld, wb_data); end
    step();
    #1;
    checks++;
    if (status !== 8'h02) begin errors++; $display("[TB] FAIL cont_done got=%h exp=02", status); end
    checks++;
    if ({wb_count - wb_before, overlap_count} !== {32'd1, 32'd0}) begin errors++; $display("[TB] FAIL cont_count got=%0d/%0d exp=1/0", wb_count - wb_before, overlap_count); end
  endtask

  task automatic test_timeout();
    wb_before = wb_count;
    start_op(8'd33, 8'd3, 8'd4, 8'd7);
    step();
    repeat (15) step();
    #1;
    checks++;
    if ({status, rsa_en} !== {8'h01, 1'b1}) begin errors++; $display("[TB] FAIL to_run16 got=%h/%b exp=01/1", status, rsa_en); end
    step();
    #1;
    checks++;
    if ({status, rsa_rst_n, rsa_en} !== {8'h04, 2'b00}) begin errors++; $display("[TB] FAIL to_idle got=%h/%b%b exp=04/00", status, rsa_rst_n, rsa_en); end
    checks++;
    if (wb_count - wb_before !== 0) begin errors++; $display("[TB] FAIL to_nowb got=%0d exp=0", wb_count - wb_before); end
  endtask

  task automatic test_eoc_at_timeout();
    wb_before = wb_count;
    start_op(8'd1, 8'd2, 8'd3, 8'd4);
    step();
    repeat (15) step();
    rsa_eoc = 1'b1; rsa_c = 8'hA5;
    step();
    rsa_eoc = 1'b0; rsa_c = 8'd0;
    #1;
    checks++;
    if ({wb_vld, wb_data, status} !== {1'b1, 8'hA5, 8'h01}) begin errors++; $display("[TB] FAIL tie_wb got=%b/%h/%h exp=1/a5/01", wb_vld, wb_data, status); end
    step();
    #1;
    checks++;
    if (status !== 8'h02) begin errors++; $display("[TB] FAIL tie_done got=%h exp=02", status); end
  endtask

  task automatic test_abort();
    wb_before = wb_count;
    start_op(8'd33, 8'd3, 8'd4, 8'd7);
    step();
    repeat (4) step();
    cmd_abort = 1'b1;
    step();
    cmd_abort = 1'b0;
    #1;
    checks++;
    if ({status, rsa_en, rsa_rst_n} !== {8'h08, 2'b00}) begin errors++; $display("[TB] FAIL abort_run got=%h/%b%b exp=08/00", status, rsa_en, rsa_rst_n); end
    start_op(8'd33, 8'd3, 8'd4, 8'd7);
    step();
    repeat (2) step();
    cmd_abort = 1'b1; rsa_eoc = 1'b1; rsa_c = 8'd55;
    step();
    cmd_abort = 1'b0; rsa_eoc = 1'b0; rsa_c = 8'd0;
    step();
    #1;
    checks++;
    if (status !== 8'h08) begin errors++; $display("[TB] FAIL abort_eoc got=%h exp=08", status); end
    start_op(8'd33, 8'd3, 8'd4, 8'd7);
    step();
    rsa_eoc = 1'b1; rsa_c = 8'd1;
    step();
    rsa_eoc = 1'b0;
    cmd_abort = 1'b1;
    #1;
    checks++;
    if (wb_vld !== 1'b0) begin errors++; $display("[TB] FAIL abort_wb_vld got=%b exp=0", wb_vld); end
    step();
    cmd_abort = 1'b0;
    #1;
    checks++;
    if (status !== 8'h08) begin errors++; $display("[TB] FAIL abort_wb got=%h exp=08", status); end
    checks++;
    if (wb_count - wb_before !== 0) begin errors++; $display("[TB] FAIL abort_nowb got=%0d exp=0", wb_count - wb_before); end
    cmd_abort = 1'b1;
    step();
    cmd_abort = 1'b0;
    #1;
    checks++;
    if ({status, rsa_rst_n} !== {8'h08, 1'b0}) begin errors++; $display("[TB] FAIL abort_idle got=%h/%b exp=08/0", status, rsa_rst_n); end
  endtask

  task automatic test_start_while_busy();
    wb_before = wb_count;
    start_op(8'd33, 8'd3, 8'd4, 8'd7);
    step();
    step();
    op_m = 8'd9;
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    #1;
    checks++;
    if ({rsa_m, status} !== {8'd4, 8'h01}) begin errors++; $display("[TB] FAIL busy_start got=%0d/%h exp=4/01", rsa_m, status); end
    rsa_eoc = 1'b1; rsa_c = 8'd31;
    step();
    rsa_eoc = 1'b0; rsa_c = 8'd0;
    #1;
    checks++;
    if ({rsa_m, wb_vld} !== {8'd4, 1'b1}) begin errors++; $display("[TB] FAIL busy_wb got=%0d/%b exp=4/1", rsa_m, wb_vld); end
    step();
    #1;
    checks++;
    if ({status, 32'(wb_count - wb_before)} !== {8'h02, 32'd1}) begin errors++; $display("[TB] FAIL busy_done got=%h/%0d exp=02/1", status, wb_count - wb_before); end
  endtask

  task automatic test_reset_mid_wb();
    wb_before = wb_count;
    start_op(8'd33, 8'd3, 8'd4, 8'd7);
    step();
    rsa_eoc = 1'b1; rsa_c = 8'd31;
    step();
    rsa_eoc = 1'b0; rsa_c = 8'd0;
    spi_wr_vld = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    spi_wr_vld = 1'b0;
    #1;
    checks++;
    if ({status, wb_vld, rsa_en, rsa_rst_n} !== {8'h00, 3'b000}) begin errors++; $display("[TB] FAIL rst_wb_ctl got=%h/%b%b%b exp=00/000", status, wb_vld, rsa_en, rsa_rst_n); end
    checks++;
    if ({rsa_p, rsa_m, wb_data} !== 24'h0) begin errors++; $display("[TB] FAIL rst_wb_regs got=%h exp=0", {rsa_p, rsa_m, wb_data}); end
    step();
    checks++;
    if (wb_count - wb_before !== 0) begin errors++; $display("[TB] FAIL rst_wb_dropped got=%0d exp=0", wb_count - wb_before); end
    start_op(8'd5, 8'd6, 8'd7, 8'd8);
    #1;
    checks++;
    if ({rsa_p, rsa_e, rsa_m, rsa_const} !== 32'h05060708) begin errors++; $display("[TB] FAIL rst_restart_latch got=%h exp=05060708", {rsa_p, rsa_e, rsa_m, rsa_const}); end
    step();
    rsa_eoc = 1'b1; rsa_c = 8'h3C;
    step();
    rsa_eoc = 1'b0; rsa_c = 8'd0;
    #1;
    checks++;
    if ({wb_vld, wb_data} !== {1'b1, 8'h3C}) begin errors++; $display("[TB] FAIL rst_restart_wb got=%b/%h exp=1/3c", wb_vld, wb_data); end
    step();
    #1;
    checks++;
    if (status !== 8'h02) begin errors++; $display("[TB] FAIL rst_restart_done got=%h exp=02", status); end
  endtask

  initial begin
    rst = 1'b1; cmd_start = 1'b0; cmd_abort = 1'b0; spi_wr_vld = 1'b0;
    op_p = '0; op_e = '0; op_m = '0; op_const = '0;
    rsa_eoc = 1'b0; rsa_c = '0;
    test_reset();
    test_basic();
    test_contention();
    test_timeout();
    test_eoc_at_timeout();
    test_abort();
    test_start_while_busy();
    test_reset_mid_wb();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rsa_ctrl.md
Name: rsa_ctrl

Overview:
- Sequencer between the SPI register bank and the rsa_unit modular-exponentiation datapath.
- On a start command it latches operands P, E, M and Const from the register bank and holds the rsa_unit in clear for one cycle. It then runs the unit until eoc or timeout.
- On eoc it writes result C back to the register bank through the bank's shared write port. SPI writes always have priority on that port.
- It exposes a status byte for SPI readback.

Parameters:
- WIDTH, 8, operand/result width.
- ADDR_W, 3, register-bank address width.
- RESULT_ADDR, 5, bank address receiving C.
- TIMEOUT_CYCLES, 4096, maximum RUN cycles before abort (range 2..65535).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cmd_start  in  1  one-cycle start pulse (CTRL register bit0 write).
- cmd_abort  in  1  one-cycle abort pulse (CTRL register bit1 write).
- op_p, op_e, op_m, op_const  in  WIDTH each  live register-bank operand values.
- spi_wr_vld  in  1  SPI write to the bank in this cycle.
- wb_vld  out  1  result write request to the bank write port.
- wb_addr  out  ADDR_W  equals RESULT_ADDR.
- wb_data  out  WIDTH  captured result.
- rsa_rst_n  out  1  datapath clear, active low.
- rsa_en  out  1  datapath enable.
- rsa_p, rsa_e, rsa_m, rsa_const  out  WIDTH each  latched operands to the datapath.
- rsa_eoc  in  1  datapath end-of-computation.
- rsa_c  in  WIDTH  datapath result.
- status  out  8  {4'b0, err_abort, err_timeout, done, busy}.

Behaviour:
- Reset values:
  - state IDLE.
  - rsa_en=0, rsa_rst_n=0, wb_vld=0.
  - All latched operands and the result register = 0.
  - status = 0; timer = 0.
- States: IDLE, LOAD, RUN, WB.
- IDLE:
  - rsa_rst_n=0, rsa_en=0, busy=0.
  - cmd_start=1 and cmd_abort=0: latch op_* into rsa_* on this edge; clear done, err_timeout and err_abort; go to LOAD.
  - cmd_abort alone in IDLE: no effect.
- LOAD (exactly 1 cycle):
  - busy=1, rsa_rst_n=0, rsa_en=0.
  - Clear the timer; go to RUN.
- RUN:
  - rsa_rst_n=1, rsa_en=1, busy=1.
  - The timer increments every RUN cycle.
  - rsa_eoc=1: capture rsa_c into the result register; go to WB.
  - If rsa_eoc is high in the same cycle the timer reaches TIMEOUT_CYCLES-1, eoc wins.
  - Timer reaches TIMEOUT_CYCLES-1 without eoc: set err_timeout; go to IDLE; no writeback.
- WB:
  - rsa_en=0, rsa_rst_n=1, busy=1.
  - wb_vld = !spi_wr_vld, i.e. SPI wins and WB holds until a free cycle.
  - Write accepted (wb_vld=1): set done; go to IDLE.
  - wb_vld never overlaps spi_wr_vld.
- cmd_abort in LOAD, RUN or WB:
  - Takes effect on that edge: go to IDLE and set err_abort.
  - wb_vld is forced 0 in that cycle, so no partial write.
  - Abort beats eoc and start in the same cycle.
- cmd_start while busy: ignored; operands are not re-latched.
- Latency: start at edge 0 → LOAD cycle 1 → first RUN cycle 2.
  - eoc at RUN cycle k → WB at k+1 → write at k+1 when the port is free → IDLE with done=1 at k+2.
- rsa_* operands stay stable from LOAD until return to IDLE.
  - Bank writes during busy do not affect the running operation.
- rst asserted mid-operation: next edge is full reset state; any pending writeback is dropped.
- done, err_timeout and err_abort are sticky until the next accepted start or rst.

Decomposition:
- Package rsa_pkg:
  - State encoding (2-bit).
  - Status bit indices: BUSY=0, DONE=1, ERR_TO=2, ERR_ABORT=3.
  - CTRL register address and bit indices: START=0, ABORT=1.
  - Default RESULT_ADDR.
- Sub-module rsa_ctrl_timer: clear/increment counter, width derived from TIMEOUT_CYCLES, with an expire output; reused by later blocks.
- FSM and writeback arbitration stay in rsa_ctrl.

Test Plan:
- Basic run: op_p=33, op_e=3, op_m=4; rsa_unit model asserts eoc after 10 RUN cycles with rsa_c=31 → wb_vld once, wb_addr=5, wb_data=31, 1 cycle after eoc; status=8'h02.
- Writeback contention: spi_wr_vld held high for 3 cycles starting at the WB cycle → wb_vld asserts only in the 4th WB cycle, no overlap, data still 31.
- Timeout: TIMEOUT_CYCLES=16, eoc never asserted → returns to IDLE after 16 RUN cycles; status=8'h04; wb_vld never asserted; rsa_rst_n low afterwards.
- Abort:
  - cmd_abort in RUN cycle 5 → IDLE next edge; status=8'h08; no write.
  - Abort and eoc in the same cycle → still no write.
- Start while busy / operand stability: second cmd_start in RUN with op_m changed to 9 → ignored; rsa_m stays 4; a single writeback occurs.
- Reset mid-WB (spi_wr_vld high so the write is pending): rst pulse → all outputs at reset values, status=0, no wb_vld; a following start runs normally.
